// File: rtl/mem_bus_arb_pkg.sv
// Shared definitions for the two-port memory bus arbiter: FSM state encoding
// and port indices.
package mem_bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic P_CPU = 1'b0;
    localparam logic P_DEV = 1'b1;

endpackage

// File: rtl/mem_bus_arb_pick.sv
// Combinational winner select between the two eligible ports, either
// round-robin against the last grant or fixed priority to port 0.
module mem_bus_arb_pick
    import mem_bus_arb_pkg::*;
#(
    parameter int RR = 1
) (
    input  logic [1:0] eligible,
    input  logic       last,
    output logic       gnt
);

    always_comb begin
        gnt = P_CPU;
        case (eligible)
            2'b10:   gnt = P_DEV;
            2'b11:   gnt = (RR != 0) ? ~last : P_CPU;
            default: gnt = P_CPU;
        endcase
    end

endmodule

// File: rtl/mem_bus_arb.sv
// Two-port arbiter and fixed-length cycle sequencer in front of a single
// registered block-RAM bank; acknowledges each completed cycle with a pulse.
module mem_bus_arb
    import mem_bus_arb_pkg::*;
#(
    parameter int AW   = 18,
    parameter int DW   = 36,
    parameter int WAIT = 3,
    parameter int RR   = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          rq0,
    input  logic          rq1,
    input  logic          wr0,
    input  logic          wr1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wd0,
    input  logic [DW-1:0] wd1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rd,
    output logic          busy,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wd,
    output logic          m_we,
    input  logic [DW-1:0] m_rd
);

    localparam logic [3:0] LAST_CNT = 4'(WAIT - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       gnt, last, wr_q, pick;
    logic [1:0] rq, armed, eligible;

    assign rq       = {rq1, rq0};
    assign eligible = rq & armed;

    mem_bus_arb_pick #(.RR(RR)) u_pick (
        .eligible (eligible),
        .last     (last),
        .gnt      (pick)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|eligible) state_nxt = ADDR;
            ADDR:    state_nxt = ACCESS;
            ACCESS:  if (cnt == LAST_CNT) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // A port re-arms only after its request is seen low; a low request wins
    // over the clear so dropping rq during the ack clock counts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed <= 2'b11;
        end else begin
            if (!rq0)                                armed[0] <= 1'b1;
            else if (state == DONE && gnt == P_CPU)  armed[0] <= 1'b0;
            if (!rq1)                                armed[1] <= 1'b1;
            else if (state == DONE && gnt == P_DEV)  armed[1] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            gnt    <= P_CPU;
            last   <= P_DEV;
            wr_q   <= 1'b0;
            m_addr <= '0;
            m_wd   <= '0;
            rd     <= '0;
        end else begin
            case (state)
                IDLE: if (|eligible) begin
                    gnt    <= pick;
                    wr_q   <= pick ? wr1   : wr0;
                    m_addr <= pick ? addr1 : addr0;
                    m_wd   <= pick ? wd1   : wd0;
                    cnt    <= '0;
                end
                ACCESS: if (cnt == LAST_CNT) begin
                    cnt <= '0;
                    if (!wr_q) rd <= m_rd;
                end else begin
                    cnt <= cnt + 4'd1;
                end
                DONE:    last <= gnt;
                default: ;
            endcase
        end
    end

    // Decoded from state so reset removes them without waiting for a clock.
    assign busy = (state != IDLE);
    assign m_we = (state == ACCESS) && wr_q;
    assign ack0 = (state == DONE) && (gnt == P_CPU);
    assign ack1 = (state == DONE) && (gnt == P_DEV);

endmodule
